qar_mem_arbiter: RTL and testbench

QAR_MEM_ARBITER -- requirements
Module: qar_mem_arbiter

---
 rtl/qar_arb_pkg.sv | 18 +
 rtl/qar_arb_pick.sv | 25 ++
 rtl/qar_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_qar_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qar_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester port indices and the read data returned on a watchdog timeout.
package qar_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    // Port indices, also the encoding of the grant output.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Read data returned to the requester when the memory never answers.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/qar_arb_pick.sv
// Two-way winner selector for the memory arbiter.
// A lone requester always wins. On a tie, PRIORITY_MODE=1 always picks the
// data port; any other mode alternates away from the port granted last.
module qar_arb_pick
    import qar_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic win
);

    // Select the winner from the current requests and the previous grant.
    always_comb begin
        win = PORT_FETCH;
        if (d_req && !i_req) begin
            win = PORT_DATA;
        end else if (i_req && d_req) begin
            win = (PRIORITY_MODE == 1) ? PORT_DATA : ~last_grant;
        end
    end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Shares one memory port between a fetch requester and a data requester.
// One transaction at a time: IDLE (arbitrate, latch request) -> ISSUE
// (mem_valid held with stable fields until mem_ready) -> RESP (one-cycle
// ready pulse to the winner) -> IDLE. Every output comes straight from a flop.
//
// Handshake: requesters hold *_valid until their *_ready pulse; the request
// is latched when accepted, so dropping valid early does not cancel it. The
// memory side sees mem_valid high for the whole ISSUE phase and completes it
// with a single mem_ready; mem_ready in any other state is ignored.
//
// Build option: define QAR_ARB_TIMEOUT_EN to add a watchdog that ends an
// ISSUE phase after TIMEOUT_CYCLES cycles, returning TIMEOUT_RDATA on reads,
// dropping writes and pulsing err with the ready. Without it err is tied 0.
module qar_mem_arbiter
    import qar_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  grant,
    output logic                  err
);

    arb_state_t            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  win;
    logic                  mem_valid_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  i_ready_d, d_ready_d;
    logic [DATA_WIDTH-1:0] i_rdata_d, d_rdata_d;
    logic                  grant_d;

`ifdef QAR_ARB_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wdog_q, wdog_d;
    logic        err_d;
`endif

    qar_arb_pick #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_pick (
        .i_req     (i_valid),
        .d_req     (d_valid),
        .last_grant(last_grant_q),
        .win       (win)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_valid_d  = mem_valid;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        grant_d      = grant;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
`ifdef QAR_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid || d_valid) begin
                    state_d      = ST_ISSUE;
                    grant_d      = win;
                    last_grant_d = win;
                    mem_valid_d  = 1'b1;
                    if (win == PORT_DATA) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
`ifdef QAR_ARB_TIMEOUT_EN
                    wdog_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    if (!mem_we) begin
                        if (grant == PORT_DATA) d_rdata_d = mem_rdata;
                        else                    i_rdata_d = mem_rdata;
                    end
                    if (grant == PORT_DATA) d_ready_d = 1'b1;
                    else                    i_ready_d = 1'b1;
                end
`ifdef QAR_ARB_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    // Memory never answered: fabricate a response.
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    if (!mem_we) begin
                        if (grant == PORT_DATA) d_rdata_d = DATA_WIDTH'(TIMEOUT_RDATA);
                        else                    i_rdata_d = DATA_WIDTH'(TIMEOUT_RDATA);
                    end
                    if (grant == PORT_DATA) d_ready_d = 1'b1;
                    else                    i_ready_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and arbitration-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_DATA;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            grant        <= PORT_FETCH;
        end else begin
            last_grant_q <= last_grant_d;
            mem_valid    <= mem_valid_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            i_ready      <= i_ready_d;
            d_ready      <= d_ready_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            grant        <= grant_d;
        end
    end

`ifdef QAR_ARB_TIMEOUT_EN
    // Watchdog counter and the timeout flag that accompanies the ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err    <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err    <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Self-checking bench for qar_mem_arbiter. Two instances share all inputs:
// dut0 is round-robin, dut1 is fixed data priority. Both accept in the same
// cycles, so one memory responder (following dut0) serves both.
module tb_qar_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_valid, d_valid, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;

    logic          i_ready0, d_ready0, mem_valid0, mem_we0, grant0, err0;
    logic [DW-1:0] i_rdata0, d_rdata0, mem_wdata0;
    logic [AW-1:0] mem_addr0;
    logic          i_ready1, d_ready1, mem_valid1, mem_we1, grant1, err1;
    logic [DW-1:0] i_rdata1, d_rdata1, mem_wdata1;
    logic [AW-1:0] mem_addr1;

    qar_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready0), .i_rdata(i_rdata0),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready0), .d_rdata(d_rdata0),
        .mem_valid(mem_valid0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant0), .err(err0)
    );

    qar_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_valid(mem_valid1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- memory responder ----------------
    logic [DW-1:0] mem_model [0:63];
    int            mem_wait;
    int            wcnt;

    initial begin
        for (int k = 0; k < 64; k++) mem_model[k] = 32'h1000_0000 + k;
        mem_model[4] = 32'h0000_0013;
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        mem_wait  = 0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (mem_valid0 && !mem_ready) begin
                if (wcnt >= mem_wait) begin
                    mem_ready = 1'b1;
                    if (mem_we0) mem_model[mem_addr0[7:2]] = mem_wdata0;
                    mem_rdata = mem_model[mem_addr0[7:2]];
                end else begin
                    wcnt++;
                    mem_ready = 1'b0;
                    mem_rdata = 32'hA5A5_A5A5;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hA5A5_A5A5;
                wcnt      = 0;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [31:0]   ia;
        logic          dv;
        logic          dwe;
        logic [31:0]   da;
        logic [31:0]   dwd;
        int            wt;
        logic          egrant;
        logic [31:0]   erdata;
    } vec_t;

    vec_t vecs [9];

    // ---------------- driver tasks ----------------
    // Present one request set at a negedge, wait for the winner's ready,
    // compare against the vector, then release the requests.
    task automatic run_vec(input vec_t v, input string tag);
        int   lat;
        logic got_i, got_d;
        mem_wait = v.wt;
        i_valid = v.iv; i_addr = v.ia;
        d_valid = v.dv; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
        lat = 0; got_i = 1'b0; got_d = 1'b0;
        while (!got_i && !got_d && lat < 50) begin
            @(negedge clk);
            lat++;
            got_i = i_ready0;
            got_d = d_ready0;
        end
        if (!got_i && !got_d) begin
            check({tag, " ready_seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, " grant"}, grant0, v.egrant);
            check({tag, " ready_pair"}, {got_i, got_d}, {~v.egrant, v.egrant});
            check({tag, " rdata"}, v.egrant ? d_rdata0 : i_rdata0, v.erdata);
            check({tag, " err"}, err0, 1'b0);
            check({tag, " latency"}, lat, v.wt + 2);
        end
        i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check({tag, " ready_one_cycle"}, i_ready0 | d_ready0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- main test ----------------
    initial begin
        int   vcnt, bad, lat, rcnt;
        logic done;

        rst = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        //                iv    ia      dv    dwe   da      dwd            wt gr    rdata
        vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,          0, 1'b0, 32'h0000_0013};
        vecs[1] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h20, 32'h0,          1, 1'b1, 32'h1000_0008};
        vecs[2] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h40, 32'h0,          0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 32'h08, 1'b1, 1'b0, 32'h0C, 32'h0,          0, 1'b0, 32'h1000_0002};
        vecs[4] = '{1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 32'h0,          2, 1'b1, 32'h1000_000D};
        vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h00, 32'h0,          0, 1'b0, 32'h1000_0011};
        vecs[6] = '{1'b1, 32'h04, 1'b1, 1'b1, 32'h50, 32'hCAFE_F00D,  1, 1'b1, 32'h1000_000D};
        vecs[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h50, 32'h0,          0, 1'b1, 32'hCAFE_F00D};
        vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0,          0, 1'b1, 32'h1000_0000};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst mem_valid", mem_valid0, 1'b0);
        check("rst mem_we", mem_we0, 1'b0);
        check("rst mem_addr", mem_addr0, 32'h0);
        check("rst mem_wdata", mem_wdata0, 32'h0);
        check("rst ready", {i_ready0, d_ready0}, 2'b00);
        check("rst i_rdata", i_rdata0, 32'h0);
        check("rst d_rdata", d_rdata0, 32'h0);
        check("rst grant", grant0, 1'b0);
        check("rst err", err0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Store with 3 wait states: request held stable for 4 cycles.
        mem_wait = 3;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        vcnt = 0; bad = 0; lat = 0; done = 1'b0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (mem_valid0) begin
                vcnt++;
                if (mem_we0 !== 1'b1 || mem_addr0 !== 32'h40 || mem_wdata0 !== 32'h1234_5678) bad++;
            end
            if (d_ready0) done = 1'b1;
        end
        check("store done", done, 1'b1);
        check("store valid_cycles", vcnt, 4);
        check("store unstable_cycles", bad, 0);
        check("store grant", grant0, 1'b1);
        check("store i_ready", i_ready0, 1'b0);
        check("store d_rdata_kept", d_rdata0, 32'h0);
        d_valid = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("store ready_one_cycle", d_ready0, 1'b0);
        check("store mem_word16", mem_model[16], 32'h1234_5678);

        // Table of single transactions.
        for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Both requesters held: round-robin alternates, fixed priority sticks to data.
        pulse_reset();
        mem_wait = 0;
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int t = 0; t < 5; t++) begin
            lat = 0; done = 1'b0;
            while (!done && lat < 20) begin
                @(negedge clk);
                lat++;
                done = i_ready0 | d_ready0;
            end
            check($sformatf("hold%0d seen", t), done, 1'b1);
            check($sformatf("hold%0d rr_grant", t), grant0, (t < 4) ? t[0] : 1'b0);
            check($sformatf("hold%0d fixed_grant", t), grant1, (t < 4) ? 1'b1 : 1'b0);
            check($sformatf("hold%0d fixed_ready", t), {i_ready1, d_ready1}, (t < 4) ? 2'b01 : 2'b10);
            if (t == 3) d_valid = 1'b0;
        end
        i_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of ISSUE abandons the transaction.
        mem_wait = 100;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        @(negedge clk);
        check("rstmid issuing", mem_valid0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rstmid mem_valid_drop", mem_valid0, 1'b0);
        d_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (i_ready0 | d_ready0) rcnt++;
        end
        check("rstmid no_ready", rcnt, 0);
        run_vec('{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 0, 1'b1, 32'h1000_0009}, "after_rst");

`ifdef QAR_ARB_TIMEOUT_EN
        // Memory never answers a load: watchdog completes it with an error.
        mem_wait = 1000;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h28;
        lat = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            done = d_ready0;
        end
        check("tmo ready", done, 1'b1);
        check("tmo err", err0, 1'b1);
        check("tmo rdata", d_rdata0, 32'hDEAD_BEEF);
        check("tmo i_ready", i_ready0, 1'b0);
        d_valid = 1'b0;
        @(negedge clk);
        check("tmo err_one_cycle", err0, 1'b0);
        check("tmo mem_valid", mem_valid0, 1'b0);
`endif

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule
